truth_table_capture: RTL and testbench



---
 rtl/truth_table_capture.sv | 123 ++++++++++++
 tb/tb_truth_table_capture.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_capture.sv
// Sweeps every input combination of a small combinational block, holding each for HOLD_CYCLES
// clocks, captures the block's output into a truth table and compares it against a reference.
module truth_table_capture #(
    parameter int unsigned N_IN        = 3,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2**N_IN-1:0]  expected,
    input  logic                m_in,
    output logic [N_IN-1:0]     vec,
    output logic                busy,
    output logic                done,
    output logic [2**N_IN-1:0]  table_out,
    output logic                mismatch
);

    localparam int unsigned TtW     = 2 ** N_IN;
    localparam int unsigned CntRawW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned CntW    = (CntRawW < 1) ? 1 : CntRawW;

    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] VecLast  = N_IN'(TtW - 1);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e            r_state;
    logic [CntW-1:0]   r_hold;
    logic [N_IN-1:0]   r_vec;
    logic [TtW-1:0]    r_shadow;
    logic [TtW-1:0]    r_exp;
    logic [TtW-1:0]    r_table;
    logic              r_mismatch;
    logic              r_done;

    state_e            w_state_d;
    logic [CntW-1:0]   w_hold_d;
    logic [N_IN-1:0]   w_vec_d;
    logic [TtW-1:0]    w_shadow_d;
    logic [TtW-1:0]    w_exp_d;
    logic [TtW-1:0]    w_table_d;
    logic              w_mismatch_d;
    logic              w_done_d;
    logic [TtW-1:0]    w_shadow_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_hold     <= '0;
            r_vec      <= '0;
            r_shadow   <= '0;
            r_exp      <= '0;
            r_table    <= '0;
            r_mismatch <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_hold     <= w_hold_d;
            r_vec      <= w_vec_d;
            r_shadow   <= w_shadow_d;
            r_exp      <= w_exp_d;
            r_table    <= w_table_d;
            r_mismatch <= w_mismatch_d;
            r_done     <= w_done_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_hold_d     = r_hold;
        w_vec_d      = r_vec;
        w_shadow_d   = r_shadow;
        w_exp_d      = r_exp;
        w_table_d    = r_table;
        w_mismatch_d = r_mismatch;
        w_done_d     = 1'b0;

        // Shadow word with the current sample merged in, so completion sees the final bit.
        w_shadow_cur        = r_shadow;
        w_shadow_cur[r_vec] = m_in;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d  = StRun;
                    w_exp_d    = expected;
                    w_shadow_d = '0;
                    w_vec_d    = '0;
                    w_hold_d   = '0;
                end
            end
            StRun: begin
                if (r_hold == HoldLast) begin
                    w_shadow_d = w_shadow_cur;
                    w_hold_d   = '0;
                    if (r_vec == VecLast) begin
                        w_table_d    = w_shadow_cur;
                        w_mismatch_d = (w_shadow_cur != r_exp);
                        w_done_d     = 1'b1;
                        w_vec_d      = '0;
                        w_state_d    = StIdle;
                    end else begin
                        w_vec_d = r_vec + N_IN'(1);
                    end
                end else begin
                    w_hold_d = r_hold + CntW'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign vec       = r_vec;
    assign busy      = (r_state == StRun);
    assign done      = r_done;
    assign table_out = r_table;
    assign mismatch  = r_mismatch;

endmodule

// File: tb/tb_truth_table_capture.sv
// Randomized sweep bench: a cycle-position model predicts vec/busy/done and the captured table
// for a default-hold instance and a HOLD_CYCLES=1 instance with start held high.
module tb_truth_table_capture;

    localparam int unsigned Tt   = 8;
    localparam int unsigned Hold = 4;

    logic          clk = 1'b0;
    logic          rst_n, start, m_in;
    logic [7:0]    expected;
    logic [2:0]    vec;
    logic          busy, done, mismatch;
    logic [7:0]    table_out;

    logic          rst_nb, start_b, m_in_b;
    logic [7:0]    expected_b;
    logic [2:0]    vec_b;
    logic          busy_b, done_b, mismatch_b;
    logic [7:0]    table_out_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    truth_table_capture #(.N_IN(3), .HOLD_CYCLES(Hold)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .expected  (expected),
        .m_in      (m_in),
        .vec       (vec),
        .busy      (busy),
        .done      (done),
        .table_out (table_out),
        .mismatch  (mismatch)
    );

    truth_table_capture #(.N_IN(3), .HOLD_CYCLES(1)) u_dut_h1 (
        .clk       (clk),
        .rst_n     (rst_nb),
        .start     (start_b),
        .expected  (expected_b),
        .m_in      (m_in_b),
        .vec       (vec_b),
        .busy      (busy_b),
        .done      (done_b),
        .table_out (table_out_b),
        .mismatch  (mismatch_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] tt_majority();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = ((i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1)) >= 2;
        return t;
    endfunction

    function automatic logic [7:0] tt_parity();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = (((i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1)) % 2) == 1;
        return t;
    endfunction

    // k counts cycles after the start edge; vector index and hold phase follow arithmetically.
    task automatic run_sweep(input logic [7:0] func, input logic [7:0] exp, input bit glitch,
                             input bit poke, input int abort_k);
        @(negedge clk);
        start    = 1'b1;
        expected = exp;
        @(posedge clk);
        for (int k = 0; k < int'(Tt * Hold); k++) begin
            int idx;
            @(negedge clk);
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                check("rst_vec", vec, 0);
                check("rst_busy", busy, 0);
                check("rst_table", table_out, 0);
                check("rst_mismatch", mismatch, 0);
                start = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("rst_no_done", done, 0);
                end
                rst_n = 1'b1;
                return;
            end
            check("run_vec", vec, k / Hold);
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            start    = poke && (k == 4 || k == 19);
            expected = (poke && k >= 4) ? 8'h00 : exp;
            idx      = k / Hold;
            m_in     = (glitch && (k % Hold != Hold - 1)) ? ~func[idx] : func[idx];
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_vec", vec, 0);
        check("table_out", table_out, func);
        check("mismatch", mismatch, func != exp);
        @(negedge clk);
        check("done_clear", done, 0);
        check("table_hold", table_out, func);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] f, e;
        int waited;
        rst_n      = 1'b0;
        rst_nb     = 1'b0;
        start      = 1'b0;
        expected   = 8'h00;
        m_in       = 1'b0;
        start_b    = 1'b1;
        m_in_b     = 1'b1;
        expected_b = 8'hFF;
        #1;
        check("reset_vec", vec, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_table", table_out, 0);
        check("reset_mismatch", mismatch, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        rst_nb = 1'b1;

        run_sweep(tt_majority(), 8'hE8, 1'b0, 1'b0, -1);
        run_sweep(tt_parity(), 8'hE8, 1'b0, 1'b0, -1);
        run_sweep(tt_parity(), 8'hE8, 1'b0, 1'b0, 13);
        run_sweep(tt_parity(), 8'h96, 1'b0, 1'b0, -1);
        run_sweep(tt_majority(), 8'hE8, 1'b0, 1'b1, -1);
        run_sweep(tt_majority(), 8'hE8, 1'b1, 1'b0, -1);
        for (int r = 0; r < 6; r++) begin
            f = 8'($urandom);
            e = ($urandom_range(0, 1) == 1) ? f : 8'($urandom);
            run_sweep(f, e, $urandom_range(0, 1) == 1, 1'b0, -1);
        end

        waited = 0;
        @(negedge clk);
        while (!done_b && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("h1_first_done", done_b, 1);
        if (done_b) begin
            for (int rep = 0; rep < 3; rep++) begin
                for (int j = 1; j <= 9; j++) begin
                    @(negedge clk);
                    if (j < 9) begin
                        check("h1_vec", vec_b, j - 1);
                        check("h1_busy", busy_b, 1);
                        check("h1_done_low", done_b, 0);
                    end else begin
                        check("h1_done_period", done_b, 1);
                        check("h1_busy_low", busy_b, 0);
                        check("h1_table", table_out_b, 8'hFF);
                        check("h1_mismatch", mismatch_b, 0);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
